seq_mult_8: RTL



---
 rtl/seq_mult_8.sv | 101 ++++++++++
 1 files changed

// File: rtl/seq_mult_8.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one 8-bit ripple-carry
// adder shared across eight iterations, registered 16-bit product.
module seq_mult_8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic        dbg_state
);

   // Handshake: start is accepted on a rising edge only while busy=0; the
   // operands are captured on that edge. done pulses for one cycle (never
   // alongside busy) when product updates; start while busy=1 is dropped.
   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state, state_n;
   logic [7:0]  m, m_n;
   logic [7:0]  q, q_n;
   logic [7:0]  p, p_n;
   logic [3:0]  cnt, cnt_n;
   logic [15:0] product_n;
   logic        done_n;

   logic [7:0]  addend;
   logic [7:0]  s;
   logic [8:0]  c;
   logic        cout;

   // Ripple-carry adder: p + (q[0] ? m : 0), carry-in tied low.
   always_comb begin
      addend = q[0] ? m : 8'h00;
      s      = 8'h00;
      c      = 9'h000;
      for (int i = 0; i < 8; i++) begin
         s[i]   = p[i] ^ addend[i] ^ c[i];
         c[i+1] = (p[i] & addend[i]) | (c[i] & (p[i] ^ addend[i]));
      end
      cout = c[8];
   end

   always_comb begin
      state_n   = state;
      m_n       = m;
      q_n       = q;
      p_n       = p;
      cnt_n     = cnt;
      product_n = product;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               m_n     = a;
               q_n     = b;
               p_n     = 8'h00;
               cnt_n   = 4'd0;
               state_n = RUN;
            end
         end
         RUN: begin
            // Shift {cout, s, q} right by one so no carry is ever lost.
            p_n   = {cout, s[7:1]};
            q_n   = {s[0], q[7:1]};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
               product_n = {cout, s, q[7:1]};
               done_n    = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         m       <= 8'h00;
         q       <= 8'h00;
         p       <= 8'h00;
         cnt     <= 4'd0;
         product <= 16'h0000;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         m       <= m_n;
         q       <= q_n;
         p       <= p_n;
         cnt     <= cnt_n;
         product <= product_n;
         done    <= done_n;
      end
   end

   assign busy      = (state == RUN);
   assign dbg_state = state;

endmodule
